sd_fifo_tail_arb: RTL

//  Read-side scheduler for N logical FIFOs sharing one synchronous RAM (one read port).

---
 rtl/sd_fifo_tail_arb_if.sv | 35 +++
 rtl/sd_fifo_tail_arb.sv | 85 ++++++++
 2 files changed

// File: rtl/sd_fifo_tail_arb_if.sv
// ============================================================================
// Module : sd_fifo_tail_arb_if
// Brief  : Pointer/handshake bundle between the shared-RAM read scheduler and
//          its environment (heads, RAM, downstream consumer).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sd_fifo_tail_arb_if #(
    parameter int QUEUES = 4,
    parameter int DEPTH  = 16
);
    localparam int ASZ = $clog2(DEPTH);
    localparam int QSZ = $clog2(QUEUES);

    logic [QUEUES*(ASZ+1)-1:0] wrptr_head;
    logic [QUEUES*(ASZ+1)-1:0] rdptr_tail;
    logic                      rd_en;
    logic [QSZ+ASZ-1:0]        rd_addr;
    logic                      p_srdy;
    logic                      p_drdy;
    logic [QSZ-1:0]            p_qid;

    // master = the scheduler, slave = heads/RAM/consumer side
    modport master (
        input  wrptr_head, p_drdy,
        output rdptr_tail, rd_en, rd_addr, p_srdy, p_qid
    );
    modport slave (
        output wrptr_head, p_drdy,
        input  rdptr_tail, rd_en, rd_addr, p_srdy, p_qid
    );
endinterface

`default_nettype wire

// File: rtl/sd_fifo_tail_arb.sv
// ============================================================================
// Module : sd_fifo_tail_arb
// Brief  : Read-side scheduler for N logical FIFOs sharing one RAM read port.
//          Round-robin by default; SDLIB_TAIL_ARB_STRICT_EN selects fixed
//          priority (lowest non-empty queue wins).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_fifo_tail_arb #(
    parameter int QUEUES = 4,
    parameter int DEPTH  = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sd_fifo_tail_arb_if.master bus
);
    localparam int ASZ = $clog2(DEPTH);
    localparam int QSZ = $clog2(QUEUES);
    localparam int PW  = ASZ + 1;
    localparam logic [QSZ-1:0] C_LAST_INIT = QSZ'(QUEUES - 1);

    logic [PW-1:0]     r_rdptr [QUEUES];
    logic [QUEUES-1:0] w_nonempty;
    logic [QSZ-1:0]    r_last_grant;
    logic [QSZ-1:0]    w_grant;
    logic [QSZ-1:0]    w_idx;
    logic [QSZ-1:0]    r_qid;
    logic              r_srdy;
    logic              w_rd_en;

    // Full-width compare: the extra MSB tells full apart from empty
    generate
        for (genvar g = 0; g < QUEUES; g++) begin : g_queue
            assign w_nonempty[g] = (bus.wrptr_head[g*PW +: PW] != r_rdptr[g]);
            assign bus.rdptr_tail[g*PW +: PW] = r_rdptr[g];
        end
    endgenerate

    always_comb begin
        w_grant = r_last_grant + QSZ'(1);
        w_idx   = '0;
`ifdef SDLIB_TAIL_ARB_STRICT_EN
        for (int i = QUEUES - 1; i >= 0; i--) begin
            if (w_nonempty[i]) w_grant = QSZ'(i);
        end
`else
        // Scan downward so the closest queue after last_grant is the final write
        for (int i = QUEUES; i >= 1; i--) begin
            w_idx = r_last_grant + QSZ'(i);
            if (w_nonempty[w_idx]) w_grant = w_idx;
        end
`endif
    end

    assign w_rd_en      = (~r_srdy | bus.p_drdy) & (|w_nonempty);
    assign bus.rd_en    = w_rd_en;
    assign bus.rd_addr  = {w_grant, r_rdptr[w_grant][ASZ-1:0]};
    assign bus.p_srdy   = r_srdy;
    assign bus.p_qid    = r_qid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int q = 0; q < QUEUES; q++) r_rdptr[q] <= '0;
        end else if (w_rd_en) begin
            r_rdptr[w_grant] <= r_rdptr[w_grant] + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_srdy       <= 1'b0;
            r_qid        <= '0;
            r_last_grant <= C_LAST_INIT;
        end else if (w_rd_en) begin
            r_srdy       <= 1'b1;
            r_qid        <= w_grant;
            r_last_grant <= w_grant;
        end else if (bus.p_drdy) begin
            r_srdy       <= 1'b0;
        end
    end
endmodule

`default_nettype wire
